output_drain_counter: RTL and testbench
=======================================

Name: output_drain_counter

Overview:
Consumer-side companion of the 4-input/4-output FIFO switching module. It watches the empty flags of output FIFOs 4-7 and issues round-robin pops to drain them. Drained words go onto a single valid/ready sink stream tagged with their source index. It also keeps per-FIFO delivered-word counters and answers the req/idx/IDLE counter query with valid_contador/contador_out.

Parameters:
data_width, 10, width of FIFO words and data_out
count_width, 5, width of each per-FIFO counter and contador_out

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-low; reset==0 at a rising edge resets the block
empty_fifos  input  4  empty flags of FIFOs 4..7 (bit0=FIFO4)
FIFO_data_out4..FIFO_data_out7  input  data_width each  FIFO read data, valid the cycle after the matching pop
sink_ready  input  1  downstream accepts data_out this cycle
req  input  1  counter query request
IDLE  input  1  system idle; queries are served only when high
idx  input  2  counter index for query (0=FIFO4 .. 3=FIFO7)
pop4, pop5, pop6, pop7  output  1 each  registered pop strobes, at most one high per cycle
data_out  output  data_width  drained word
dest_out  output  2  source FIFO index of data_out
valid_out  output  1  data_out/dest_out valid
valid_contador  output  1  contador_out valid
contador_out  output  count_width  queried counter value

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Clock port is clk, reset port is reset.
- Reset values: pops 0, valid_out 0, data_out 0, dest_out 0, valid_contador 0, contador_out 0, all counters 0, RR pointer 0, skid buffer empty, FSM=INIT.
- Reset mid-operation discards in-flight and buffered words. Words popped but not delivered are lost, and this is legal.
- FSM states:
  - INIT: one cycle after reset release, no pops; goes to SCAN.
  - SCAN: no eligible FIFO; stays in SCAN until one is eligible, then POP.
  - POP: a pop is asserted this cycle. Goes to POP if another FIFO is eligible, otherwise to SCAN.
- Eligibility of FIFO n (all must hold):
  - empty_fifos[n]==0;
  - n was not popped in the previous cycle, so a FIFO is never popped two cycles in a row;
  - credit available: buffered words + in-flight words < 2.
- Arbitration: round-robin starting at the RR pointer. After a pop of n, pointer = n+1 mod 4.
- Pops are registered. The decision is made in cycle t-1 and the strobe is high in cycle t.
- Latency: pop in cycle t; FIFO data sampled at the end of t+1; word enters the 2-entry skid buffer. valid_out is high at the earliest in t+2 (2-cycle pop-to-valid when the buffer is empty).
- Sink handshake:
  - Transfer occurs when valid_out && sink_ready at a rising edge.
  - data_out and dest_out are held stable while valid_out && !sink_ready.
  - Words leave in pop order; there is no reordering.
- Backpressure: credit counting guarantees the buffer never overflows. With sink_ready held low, at most 2 pops occur, then pops stop.
- Counters: count[dest_out] increments on each transfer. Width is count_width, wrapping 31 -> 0 with no saturation.
- Query:
  - At each rising edge with reset==1: if req && IDLE, then next cycle valid_contador=1 and contador_out=count[idx] (value before any same-edge increment).
  - Otherwise valid_contador=0 and contador_out=0.
  - A held req gives one result per cycle and follows idx changes.
- Query while draining is legal and does not stall draining.
- All four FIFOs empty: no pops, valid_out drops after the buffer drains.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, empty_fifos=4'hF → all outputs 0; after release with req=1, IDLE=1, idx=2 → valid_contador=1, contador_out=0.
- Round-robin drain: FIFOs 4-7 each hold 3 words (e.g. 10'h090, 10'h200, 10'h290, 10'h390 +1 steps), sink_ready=1 → pop order 4,5,6,7 repeating; 12 words out with dest_out 0,1,2,3,...; first valid_out 2 cycles after first pop.
- Single non-empty FIFO: only FIFO5 holds 4 words → pop5 never high in two consecutive cycles; 4 words arrive in order with dest_out=1.
- Backpressure: sink_ready=0 with all FIFOs full → exactly 2 pops, then none. valid_out and data_out hold the first word. Raising sink_ready resumes draining with no word lost or duplicated.
- Counter query/wrap: deliver 33 words from FIFO7, then req=1, IDLE=1, idx=3 → contador_out=1; with IDLE=0 → valid_contador=0, contador_out=0.
- Reset mid-drain: reset=0 while two words are buffered → valid_out=0 next cycle, counters 0, draining restarts from FIFO4 after INIT.

Source files
------------

// File: rtl/output_drain_counter_if.sv
// Bundle of the FIFO-side, sink-side and counter-query signals of output_drain_counter.
// master = environment (FIFOs, sink, query requester), slave = the drain/counter block.
interface output_drain_counter_if #(
  parameter int data_width  = 10,
  parameter int count_width = 5
);
  logic [3:0]             empty_fifos;
  logic [data_width-1:0]  FIFO_data_out4;
  logic [data_width-1:0]  FIFO_data_out5;
  logic [data_width-1:0]  FIFO_data_out6;
  logic [data_width-1:0]  FIFO_data_out7;
  logic                   sink_ready;
  logic                   req;
  logic                   IDLE;
  logic [1:0]             idx;
  logic                   pop4;
  logic                   pop5;
  logic                   pop6;
  logic                   pop7;
  logic [data_width-1:0]  data_out;
  logic [1:0]             dest_out;
  logic                   valid_out;
  logic                   valid_contador;
  logic [count_width-1:0] contador_out;

  modport master (
    output empty_fifos, FIFO_data_out4, FIFO_data_out5, FIFO_data_out6, FIFO_data_out7,
    output sink_ready, req, IDLE, idx,
    input  pop4, pop5, pop6, pop7, data_out, dest_out, valid_out, valid_contador, contador_out
  );

  modport slave (
    input  empty_fifos, FIFO_data_out4, FIFO_data_out5, FIFO_data_out6, FIFO_data_out7,
    input  sink_ready, req, IDLE, idx,
    output pop4, pop5, pop6, pop7, data_out, dest_out, valid_out, valid_contador, contador_out
  );
endinterface

// File: rtl/output_drain_counter.sv
// Round-robin drain of output FIFOs 4..7 into one tagged valid/ready stream, with
// per-FIFO delivered-word counters readable through the req/idx/IDLE query port.
module output_drain_counter #(
  parameter int data_width  = 10,
  parameter int count_width = 5
) (
  input logic                  clk,
  input logic                  reset,
  output_drain_counter_if.slave bus
);

  typedef enum logic [1:0] {INIT, SCAN, POP} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             pop_q, pop_d;
  logic [1:0]             ptr_q, ptr_d;
  logic                   s1_valid_q, s1_valid_d;
  logic [1:0]             s1_idx_q, s1_idx_d;
  logic [data_width-1:0]  buf_data_q [2];
  logic [data_width-1:0]  buf_data_d [2];
  logic [1:0]             buf_dest_q [2];
  logic [1:0]             buf_dest_d [2];
  logic [1:0]             buf_cnt_q, buf_cnt_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic                   valid_contador_q, valid_contador_d;
  logic [count_width-1:0] contador_q, contador_d;
  logic [count_width-1:0] count_cur [4];

  logic [data_width-1:0]  fifo_data [4];
  logic                   xfer;
  logic [2:0]             occupancy;
  logic                   credit_ok;
  logic [3:0]             eligible;
  logic                   grant_any;
  logic [1:0]             grant_idx;
  logic [1:0]             cand;
  logic                   push;
  logic                   wr_ptr;
  logic [1:0]             head_dest;

  assign fifo_data[0] = bus.FIFO_data_out4;
  assign fifo_data[1] = bus.FIFO_data_out5;
  assign fifo_data[2] = bus.FIFO_data_out6;
  assign fifo_data[3] = bus.FIFO_data_out7;

  assign head_dest = buf_dest_q[rd_ptr_q];
  assign xfer      = (buf_cnt_q != 2'd0) && bus.sink_ready;

  // A word leaving this cycle frees its slot before any newly granted pop can land
  // (that word is captured two edges later), so it is credited back immediately.
  always_comb begin
    occupancy = 3'(buf_cnt_q) + 3'(|pop_q) + 3'(s1_valid_q) - 3'(xfer);
    credit_ok = occupancy < 3'd2;
    eligible  = ~bus.empty_fifos & ~pop_q & {4{credit_ok}};
    grant_any = 1'b0;
    grant_idx = ptr_q;
    cand      = ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!grant_any && eligible[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pop_d   = 4'b0000;
    ptr_d   = ptr_q;
    case (state_q)
      INIT: state_d = SCAN;
      SCAN, POP: begin
        if (grant_any) begin
          state_d = POP;
          pop_d   = 4'b0001 << grant_idx;
          ptr_d   = grant_idx + 2'd1;
        end else begin
          state_d = SCAN;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Pop in cycle t -> s1 tracks it in t+1 -> FIFO data captured into the skid buffer at end of t+1.
  always_comb begin
    s1_valid_d = |pop_q;
    s1_idx_d   = pop_q[1] ? 2'd1 : pop_q[2] ? 2'd2 : pop_q[3] ? 2'd3 : 2'd0;
    push       = s1_valid_q;
    wr_ptr     = rd_ptr_q ^ buf_cnt_q[0];
    buf_data_d = buf_data_q;
    buf_dest_d = buf_dest_q;
    if (push) begin
      buf_data_d[wr_ptr] = fifo_data[s1_idx_q];
      buf_dest_d[wr_ptr] = s1_idx_q;
    end
    rd_ptr_d  = rd_ptr_q ^ xfer;
    buf_cnt_d = buf_cnt_q + 2'(push) - 2'(xfer);
  end

  always_comb begin
    valid_contador_d = bus.req && bus.IDLE;
    contador_d       = '0;
    if (bus.req && bus.IDLE) begin
      contador_d = count_cur[bus.idx];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cnt
      logic [count_width-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (xfer && (head_dest == 2'(gi))) begin
          cnt_d = cnt_q + count_width'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign count_cur[gi] = cnt_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= INIT;
      pop_q            <= 4'b0000;
      ptr_q            <= 2'd0;
      s1_valid_q       <= 1'b0;
      s1_idx_q         <= 2'd0;
      buf_cnt_q        <= 2'd0;
      rd_ptr_q         <= 1'b0;
      valid_contador_q <= 1'b0;
      contador_q       <= '0;
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_dest_q[i] <= 2'd0;
      end
    end else begin
      state_q          <= state_d;
      pop_q            <= pop_d;
      ptr_q            <= ptr_d;
      s1_valid_q       <= s1_valid_d;
      s1_idx_q         <= s1_idx_d;
      buf_cnt_q        <= buf_cnt_d;
      rd_ptr_q         <= rd_ptr_d;
      valid_contador_q <= valid_contador_d;
      contador_q       <= contador_d;
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= buf_data_d[i];
        buf_dest_q[i] <= buf_dest_d[i];
      end
    end
  end

  assign bus.pop4           = pop_q[0];
  assign bus.pop5           = pop_q[1];
  assign bus.pop6           = pop_q[2];
  assign bus.pop7           = pop_q[3];
  assign bus.valid_out      = (buf_cnt_q != 2'd0);
  assign bus.data_out       = buf_data_q[rd_ptr_q];
  assign bus.dest_out       = head_dest;
  assign bus.valid_contador = valid_contador_q;
  assign bus.contador_out   = contador_q;

endmodule

// File: tb/tb_output_drain_counter.sv
// Directed bench for output_drain_counter: behavioural FIFOs 4..7, a stream/pop monitor,
// a query vector table and hand-written drain, backpressure, reset and wrap sequences.
module tb_output_drain_counter;
  localparam int DW = 10;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  output_drain_counter_if #(.data_width(DW), .count_width(CW)) bus ();
  output_drain_counter #(.data_width(DW), .count_width(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          phase;
    logic        req;
    logic        idle;
    logic [1:0]  idx;
    logic        exp_vc;
    logic [CW-1:0] exp_cnt;
  } qvec_t;

  typedef struct { int cyc; logic [1:0] idx; } pop_t;
  typedef struct { int cyc; logic [DW-1:0] data; logic [1:0] dest; } rx_t;

  qvec_t qv[$];
  pop_t  pop_log[$];
  rx_t   rx_log[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    viol_cnt = 0;

  // Behavioural FIFOs: registered read, data valid the cycle after the pop.
  logic [DW-1:0] fq [4][$];
  logic [DW-1:0] fdata [4] = '{default: '0};
  logic [3:0]    empty_r = 4'hF;
  logic [3:0]    pops;
  logic [3:0]    prev_pops = 4'b0000;

  assign bus.empty_fifos    = empty_r;
  assign bus.FIFO_data_out4 = fdata[0];
  assign bus.FIFO_data_out5 = fdata[1];
  assign bus.FIFO_data_out6 = fdata[2];
  assign bus.FIFO_data_out7 = fdata[3];
  assign pops = {bus.pop7, bus.pop6, bus.pop5, bus.pop4};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int n = 0; n < 4; n++) begin
      if (pops[n] && fq[n].size() > 0) fdata[n] <= fq[n].pop_front();
      empty_r[n] <= (fq[n].size() == 0);
    end
  end

  function automatic logic [1:0] enc(logic [3:0] p);
    return p[1] ? 2'd1 : p[2] ? 2'd2 : p[3] ? 2'd3 : 2'd0;
  endfunction

  always @(negedge clk) begin
    logic bad;
    bad = ($countones(pops) > 1) || ((pops & prev_pops) != 4'b0000);
    for (int n = 0; n < 4; n++) if (pops[n] && fq[n].size() == 0) bad = 1'b1;
    if (bad) viol_cnt = viol_cnt + 1;
    if (pops != 4'b0000) pop_log.push_back('{cyc, enc(pops)});
    if (bus.valid_out && bus.sink_ready) rx_log.push_back('{cyc, bus.data_out, bus.dest_out});
    prev_pops = pops;
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(int n, logic [DW-1:0] base, int cnt);
    for (int i = 0; i < cnt; i++) fq[n].push_back(base + DW'(i));
  endtask

  task automatic clear_logs();
    pop_log.delete();
    rx_log.delete();
  endtask

  task automatic wait_rx(string name, int n, int budget);
    int c = 0;
    while (rx_log.size() < n && c < budget) begin
      tick();
      c++;
    end
    chk(name, rx_log.size(), n);
  endtask

  task automatic run_queries(int phase);
    foreach (qv[i]) begin
      if (qv[i].phase == phase) begin
        bus.req  = qv[i].req;
        bus.IDLE = qv[i].idle;
        bus.idx  = qv[i].idx;
        tick();
        $display("query phase=%0d req=%0b idle=%0b idx=%0d -> valid=%0b count=%0d",
                 phase, qv[i].req, qv[i].idle, qv[i].idx, bus.valid_contador, bus.contador_out);
        chk($sformatf("q%0d_valid", i), bus.valid_contador, qv[i].exp_vc);
        chk($sformatf("q%0d_count", i), bus.contador_out, qv[i].exp_cnt);
      end
    end
    bus.req = 1'b0;
    bus.IDLE = 1'b0;
  endtask

  logic [DW-1:0] rr_base [4];
  logic [1:0]    bp_ord [4];

  initial begin
    // phase, req, IDLE, idx, expected valid_contador, expected contador_out
    qv.push_back('{0, 1'b1, 1'b1, 2'd2, 1'b1, 5'd0});
    qv.push_back('{1, 1'b1, 1'b1, 2'd0, 1'b1, 5'd3});
    qv.push_back('{1, 1'b1, 1'b1, 2'd3, 1'b1, 5'd3});
    qv.push_back('{1, 1'b1, 1'b0, 2'd1, 1'b0, 5'd0});
    qv.push_back('{1, 1'b0, 1'b1, 2'd2, 1'b0, 5'd0});
    qv.push_back('{2, 1'b1, 1'b1, 2'd1, 1'b1, 5'd11});
    qv.push_back('{2, 1'b1, 1'b1, 2'd2, 1'b1, 5'd7});
    qv.push_back('{3, 1'b1, 1'b1, 2'd0, 1'b1, 5'd0});
    qv.push_back('{3, 1'b1, 1'b1, 2'd3, 1'b1, 5'd0});
    qv.push_back('{4, 1'b1, 1'b1, 2'd3, 1'b1, 5'd1});
    qv.push_back('{4, 1'b1, 1'b0, 2'd3, 1'b0, 5'd0});
    qv.push_back('{4, 1'b0, 1'b1, 2'd3, 1'b0, 5'd0});
    qv.push_back('{4, 1'b1, 1'b1, 2'd0, 1'b1, 5'd0});
    qv.push_back('{4, 1'b1, 1'b1, 2'd3, 1'b1, 5'd1});
    rr_base = '{10'h090, 10'h200, 10'h290, 10'h390};
    bp_ord  = '{2'd2, 2'd3, 2'd0, 2'd1};

    bus.sink_ready = 1'b0;
    bus.req = 1'b0;
    bus.IDLE = 1'b0;
    bus.idx = 2'd0;

    // Reset state
    tick(2);
    chk("rst_pops", pops, 0);
    chk("rst_valid_out", bus.valid_out, 0);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_dest_out", bus.dest_out, 0);
    chk("rst_valid_contador", bus.valid_contador, 0);
    chk("rst_contador_out", bus.contador_out, 0);
    reset = 1'b1;
    run_queries(0);

    // Round-robin drain, 3 words per FIFO
    clear_logs();
    bus.sink_ready = 1'b1;
    for (int n = 0; n < 4; n++) load(n, rr_base[n], 3);
    wait_rx("rr_words", 12, 200);
    chk("rr_pop_count", pop_log.size(), 12);
    for (int k = 0; k < 12 && k < pop_log.size() && k < rx_log.size(); k++) begin
      $display("rr word %0d: pop=%0d data=%0h dest=%0d", k, pop_log[k].idx, rx_log[k].data, rx_log[k].dest);
      chk($sformatf("rr_pop%0d", k), pop_log[k].idx, k % 4);
      chk($sformatf("rr_dest%0d", k), rx_log[k].dest, k % 4);
      chk($sformatf("rr_data%0d", k), rx_log[k].data, rr_base[k % 4] + DW'(k / 4));
    end
    if (pop_log.size() > 0 && rx_log.size() > 0)
      chk("rr_latency", rx_log[0].cyc - pop_log[0].cyc, 2);
    tick(2);
    run_queries(1);

    // Single FIFO5 with 4 words
    clear_logs();
    load(1, 10'h050, 4);
    wait_rx("single_words", 4, 100);
    chk("single_pop_count", pop_log.size(), 4);
    for (int k = 0; k < 4 && k < rx_log.size(); k++) begin
      $display("single word %0d: data=%0h dest=%0d", k, rx_log[k].data, rx_log[k].dest);
      chk($sformatf("single_dest%0d", k), rx_log[k].dest, 1);
      chk($sformatf("single_data%0d", k), rx_log[k].data, 10'h050 + DW'(k));
    end
    for (int k = 1; k < pop_log.size(); k++)
      chk($sformatf("single_gap%0d", k), (pop_log[k].cyc - pop_log[k-1].cyc) >= 2, 1);

    // Backpressure with all FIFOs holding 4 words
    bus.sink_ready = 1'b0;
    clear_logs();
    for (int n = 0; n < 4; n++) load(n, 10'h100 + DW'(n * 32), 4);
    tick(20);
    chk("bp_pop_count", pop_log.size(), 2);
    if (pop_log.size() >= 2) begin
      chk("bp_pop0", pop_log[0].idx, 2);
      chk("bp_pop1", pop_log[1].idx, 3);
    end
    chk("bp_valid", bus.valid_out, 1);
    chk("bp_data", bus.data_out, 10'h140);
    chk("bp_dest", bus.dest_out, 2);
    tick(5);
    chk("bp_pop_count_hold", pop_log.size(), 2);
    chk("bp_data_hold", bus.data_out, 10'h140);
    bus.sink_ready = 1'b1;
    wait_rx("bp_words", 16, 300);
    for (int k = 0; k < 16 && k < rx_log.size(); k++) begin
      $display("bp word %0d: data=%0h dest=%0d", k, rx_log[k].data, rx_log[k].dest);
      chk($sformatf("bp_dest%0d", k), rx_log[k].dest, bp_ord[k % 4]);
      chk($sformatf("bp_data%0d", k), rx_log[k].data,
          10'h100 + DW'(32 * int'(bp_ord[k % 4])) + DW'(k / 4));
    end
    tick(2);
    run_queries(2);

    // Reset while two words are buffered
    bus.sink_ready = 1'b0;
    clear_logs();
    for (int n = 0; n < 4; n++) load(n, 10'h200 + DW'(n * 32), 4);
    tick(10);
    chk("mid_valid_before", bus.valid_out, 1);
    reset = 1'b0;
    tick();
    chk("mid_valid_after", bus.valid_out, 0);
    chk("mid_pops_after", pops, 0);
    chk("mid_data_after", bus.data_out, 0);
    clear_logs();
    reset = 1'b1;
    run_queries(3);
    bus.sink_ready = 1'b1;
    wait_rx("mid_words", 14, 300);
    if (pop_log.size() > 0) chk("mid_first_pop", pop_log[0].idx, 0);
    if (rx_log.size() > 0) begin
      chk("mid_first_data", rx_log[0].data, 10'h200);
      chk("mid_first_dest", rx_log[0].dest, 0);
    end

    // Counter wrap: 33 words from FIFO7 after a fresh reset
    tick(4);
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    clear_logs();
    load(3, 10'h300, 33);
    wait_rx("wrap_words", 33, 400);
    for (int k = 0; k < 33 && k < rx_log.size(); k++) begin
      chk($sformatf("wrap_dest%0d", k), rx_log[k].dest, 3);
      chk($sformatf("wrap_data%0d", k), rx_log[k].data, 10'h300 + DW'(k));
    end
    tick(2);
    run_queries(4);

    chk("pop_rule_violations", viol_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
